// File: rtl/xtensa_0_if.sv
// Export-state bus between the producer-side driver and an xtensa_0 instance.
interface xtensa_0_if;
  logic        ExpStWrEn;
  logic [31:0] ExpStWrData;
  logic [31:0] ExpStWrMask;
  logic        IntAck;
  logic [31:0] TIE_EXPSTATE;
  logic        BInterrupt06;
  logic [15:0] ExpStWrCount;

  // Side that issues writes and acknowledges the interrupt.
  modport master (
    output ExpStWrEn, ExpStWrData, ExpStWrMask, IntAck,
    input  TIE_EXPSTATE, BInterrupt06, ExpStWrCount
  );

  // Side that holds the exported state.
  modport slave (
    input  ExpStWrEn, ExpStWrData, ExpStWrMask, IntAck,
    output TIE_EXPSTATE, BInterrupt06, ExpStWrCount
  );
endinterface

// File: rtl/xtensa_0.sv
// Exported TIE state register with masked writes, accepted-write counter and
// a level interrupt raised when a write takes INT_BIT from 0 to 1.
module xtensa_0 #(
  parameter logic [31:0] EXPSTATE_RESET = 32'h0000_0000,
  parameter int unsigned INT_BIT        = 0
) (
  input logic        CLK,
  input logic        BReset,
  xtensa_0_if.slave  bus
);

  logic [31:0] r_state;
  logic        r_pending;
  logic [15:0] r_count;

  logic [31:0] w_state_nxt;
  logic        w_set;

  // Merge write data into the current state bit by bit and detect a rising INT_BIT.
  always_comb begin
    w_state_nxt = r_state;
    w_set       = 1'b0;
    if (bus.ExpStWrEn) begin
      w_state_nxt = (r_state & ~bus.ExpStWrMask) | (bus.ExpStWrData & bus.ExpStWrMask);
      w_set       = ~r_state[INT_BIT] & w_state_nxt[INT_BIT];
    end
  end

  // State, counter and pending flag; reset discards any same-cycle write or ack.
  // NOTE: non-blocking assignments so every register samples pre-edge values,
  // and reset is checked first inside the clocked block to make it synchronous.
  always_ff @(posedge CLK) begin
    if (BReset) begin
      r_state   <= EXPSTATE_RESET;
      r_pending <= 1'b0;
      r_count   <= 16'h0000;
    end else begin
      r_state   <= w_state_nxt;
      // A new set beats a simultaneous acknowledge.
      r_pending <= w_set | (r_pending & ~bus.IntAck);
      if (bus.ExpStWrEn) r_count <= r_count + 16'h0001;
    end
  end

  // Outputs come straight from registers: no input-to-output combinational path.
  assign bus.TIE_EXPSTATE = r_state;
  assign bus.BInterrupt06 = r_pending;
  assign bus.ExpStWrCount = r_count;

endmodule

// File: tb/tb_xtensa_0.sv
// Self-checking bench for xtensa_0: directed steps feed a reference model whose
// expected outputs go through a scoreboard queue and are compared after each edge.
module tb_xtensa_0;

  typedef struct packed {
    logic [31:0] st;
    logic        irq;
    logic [15:0] cnt;
  } exp_t;

  logic CLK;
  logic BReset;
  int   checks = 0;
  int   errors = 0;

  exp_t sb[$];

  logic [31:0] m_st;
  logic        m_pend;
  logic [15:0] m_cnt;

  xtensa_0_if bus ();
  xtensa_0_if cbus ();

  xtensa_0 dut (
    .CLK    (CLK),
    .BReset (BReset),
    .bus    (bus)
  );

  // Consumer-side position: never written, reset value has INT_BIT already set.
  xtensa_0 #(.EXPSTATE_RESET(32'h0000_0020), .INT_BIT(5)) consumer (
    .CLK    (CLK),
    .BReset (BReset),
    .bus    (cbus)
  );

  assign cbus.ExpStWrEn   = 1'b0;
  assign cbus.ExpStWrData = 32'hFFFF_FFFF;
  assign cbus.ExpStWrMask = 32'hFFFF_FFFF;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one cycle, advance the model, push the expectation, then pop and compare.
  task automatic step(input string tag, input logic rst, input logic en,
                      input logic [31:0] data, input logic [31:0] mask, input logic ack);
    logic [31:0] nxt;
    logic        set;
    exp_t        e;
    BReset          = rst;
    bus.ExpStWrEn   = en;
    bus.ExpStWrData = data;
    bus.ExpStWrMask = mask;
    bus.IntAck      = ack;
    if (rst) begin
      m_st   = 32'h0000_0000;
      m_pend = 1'b0;
      m_cnt  = 16'h0000;
    end else begin
      set = 1'b0;
      if (en) begin
        nxt   = (m_st & ~mask) | (data & mask);
        set   = (m_st[0] == 1'b0) && (nxt[0] == 1'b1);
        m_st  = nxt;
        m_cnt = m_cnt + 16'h0001;
      end
      m_pend = set | (m_pend & ~ack);
    end
    sb.push_back('{st: m_st, irq: m_pend, cnt: m_cnt});
    @(posedge CLK);
    #1;
    e = sb.pop_front();
    chk({tag, "_state"}, {16'h0, bus.TIE_EXPSTATE}, {16'h0, e.st});
    chk({tag, "_irq"},   {47'h0, bus.BInterrupt06}, {47'h0, e.irq});
    chk({tag, "_count"}, {32'h0, bus.ExpStWrCount}, {32'h0, e.cnt});
  endtask

  initial begin
    BReset = 1'b1;
    bus.ExpStWrEn = 1'b0; bus.ExpStWrData = '0; bus.ExpStWrMask = '0; bus.IntAck = 1'b0;
    cbus.IntAck = 1'b0;
    m_st = '0; m_pend = 1'b0; m_cnt = '0;

    // Reset with a concurrent full write and ack: write discarded and not counted.
    step("rst0", 1'b1, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    step("rst1", 1'b1, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    chk("rst_state_const", {16'h0, bus.TIE_EXPSTATE}, 48'h0);
    chk("consumer_rst", {cbus.TIE_EXPSTATE, 15'h0, cbus.BInterrupt06}, {32'h0000_0020, 16'h0000});

    // First write after reset: accepted on the first non-reset edge, raises irq.
    step("wr1", 1'b0, 1'b1, 32'h0000_0001, 32'hFFFF_FFFF, 1'b0);
    chk("wr1_const", {bus.TIE_EXPSTATE, 7'h0, bus.BInterrupt06, bus.ExpStWrCount[7:0]},
        {32'h0000_0001, 7'h0, 1'b1, 8'h01});

    // Acknowledge clears; writing 3 keeps bit0 at 1 so no new interrupt.
    step("ack1", 1'b0, 1'b0, 32'hDEAD_BEEF, 32'hFFFF_FFFF, 1'b1);
    step("wr3",  1'b0, 1'b1, 32'h0000_0003, 32'hFFFF_FFFF, 1'b0);
    chk("wr3_const", {bus.TIE_EXPSTATE, 7'h0, bus.BInterrupt06, bus.ExpStWrCount[7:0]},
        {32'h0000_0003, 7'h0, 1'b0, 8'h02});

    // Partial-mask merge.
    step("ld_aa", 1'b0, 1'b1, 32'hAAAA_5555, 32'hFFFF_FFFF, 1'b0);
    step("merge", 1'b0, 1'b1, 32'hFFFF_FFFF, 32'h0000_FF00, 1'b0);
    chk("merge_const", {16'h0, bus.TIE_EXPSTATE}, {16'h0, 32'hAAAA_FF55});

    // Mask zero: counted, state unchanged. Idle cycle ignores data/mask.
    step("mask0", 1'b0, 1'b1, 32'h1234_5678, 32'h0000_0000, 1'b0);
    step("idle",  1'b0, 1'b0, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0);

    // Clearing INT_BIT does not set; re-setting does; clearing again keeps pending.
    step("clr0",  1'b0, 1'b1, 32'h0000_0000, 32'h0000_0001, 1'b0);
    step("set0",  1'b0, 1'b1, 32'h0000_0001, 32'h0000_0001, 1'b0);
    step("clr0b", 1'b0, 1'b1, 32'h0000_0000, 32'h0000_0001, 1'b0);
    chk("pend_held", {47'h0, bus.BInterrupt06}, 48'h1);

    // Ack and set in the same cycle: set wins.
    step("ack_set", 1'b0, 1'b1, 32'h0000_0001, 32'h0000_0001, 1'b1);
    chk("ack_set_const", {47'h0, bus.BInterrupt06}, 48'h1);
    step("ack2",    1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
    step("ack_idle", 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);

    // Back-to-back random writes with random acks.
    for (int i = 0; i < 40; i++)
      step("b2b", 1'b0, 1'b1, $urandom, $urandom, 1'($urandom_range(0, 1)));

    // Reset, then 0x10000 mask-zero writes: count wraps back to zero.
    step("rst2", 1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
    for (int i = 0; i < 32'h10000; i++)
      step("wrap", 1'b0, 1'b1, $urandom, 32'h0, 1'b0);
    chk("wrap_const", {bus.TIE_EXPSTATE, bus.ExpStWrCount}, 48'h0);

    // Move state off reset, then reset concurrent with a full write.
    step("pre_rst", 1'b0, 1'b1, 32'h0000_00F1, 32'hFFFF_FFFF, 1'b0);
    step("rst3", 1'b1, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    chk("rst3_const", {bus.TIE_EXPSTATE, 7'h0, bus.BInterrupt06, bus.ExpStWrCount[7:0]}, 48'h0);

    // Consumer instance never moves and never interrupts.
    chk("consumer_end", {cbus.TIE_EXPSTATE, 15'h0, cbus.BInterrupt06},
        {32'h0000_0020, 16'h0000});
    chk("consumer_cnt", {32'h0, cbus.ExpStWrCount}, 48'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/xtensa_0.md
XTENSA_0 -- requirements
Module: xtensa_0

Interface
REQ-001 Parameter EXPSTATE_RESET, default 32'h0000_0000, reset value of TIE_EXPSTATE.
REQ-002 Parameter INT_BIT, default 0, index (0..31) of the TIE_EXPSTATE bit that raises BInterrupt06.
REQ-003 CLK  input  1  sole clock; all state updates on the rising edge.
REQ-004 BReset  input  1  reset, synchronous, active-high.
REQ-005 ExpStWrEn  input  1  export-state write strobe, one write per cycle when high.
REQ-006 ExpStWrData  input  32  write data.
REQ-007 ExpStWrMask  input  32  per-bit write enable; 1 = bit takes ExpStWrData.
REQ-008 IntAck  input  1  interrupt acknowledge from the consumer core.
REQ-009 TIE_EXPSTATE  output  32  registered exported state.
REQ-010 BInterrupt06  output  1  registered level interrupt to the consumer core.
REQ-011 ExpStWrCount  output  16  registered count of accepted writes.

Function
REQ-012 With ExpStWrEn=1, next TIE_EXPSTATE SHALL be (TIE_EXPSTATE & ~ExpStWrMask) | (ExpStWrData & ExpStWrMask), visible one cycle after the strobe.
REQ-013 With ExpStWrEn=0, TIE_EXPSTATE SHALL hold; ExpStWrData and ExpStWrMask are don't-care.
REQ-014 A write with ExpStWrMask=0 SHALL leave TIE_EXPSTATE unchanged and SHALL still count as accepted.
REQ-015 ExpStWrCount SHALL increment by 1 per accepted write and SHALL wrap from 16'hFFFF to 16'h0000.
REQ-016 An internal pending flag SHALL set on any cycle where a write drives TIE_EXPSTATE[INT_BIT] from 0 to 1.
REQ-017 BInterrupt06 SHALL equal the pending flag and SHALL assert on the same edge that TIE_EXPSTATE updates.
REQ-018 A write that leaves INT_BIT at 1 (already 1) or clears it SHALL NOT set pending.
REQ-019 Clearing INT_BIT SHALL NOT clear pending; only IntAck or reset clears it.
REQ-020 IntAck=1 with no simultaneous set SHALL clear pending on the next edge.
REQ-021 Simultaneous set and IntAck: set SHALL win, so BInterrupt06 stays or goes 1.
REQ-022 IntAck while pending=0 SHALL have no effect.
REQ-023 Back-to-back writes every cycle SHALL all be applied in order with no stalls.
REQ-024 Module SHALL have no combinational path from any input to any output.
REQ-025 A consumer-side instance (second core position) SHALL use this same module with ExpStWrEn tied low; outputs then stay at reset values.

Reset
REQ-026 While BReset=1 at a rising edge: TIE_EXPSTATE=EXPSTATE_RESET, BInterrupt06=0, ExpStWrCount=0, pending=0.
REQ-027 Reset SHALL take priority over a simultaneous write or IntAck; that write is discarded and not counted.
REQ-028 EXPSTATE_RESET with INT_BIT=1 SHALL NOT raise BInterrupt06 at or after reset.
REQ-029 First write SHALL be accepted on the first edge with BReset=0.

Verification
REQ-030 Reset, then write data 32'h0000_0001 mask 32'hFFFF_FFFF -> next cycle TIE_EXPSTATE=0x00000001, BInterrupt06=1, count=1.
REQ-031 From 0x00000001 with pending=1, pulse IntAck -> BInterrupt06=0; then write 0x00000003 full mask -> no interrupt (bit0 stays 1), count increments.
REQ-032 State 0xAAAA5555, write data 0xFFFFFFFF mask 0x0000FF00 -> TIE_EXPSTATE=0xAAAAFF55.
REQ-033 IntAck in the same cycle as a 0->1 write on INT_BIT -> BInterrupt06=1 the next cycle.
REQ-034 0x10000 consecutive writes with mask 0 -> TIE_EXPSTATE unchanged, count back to 0x0000.
REQ-035 Assert BReset concurrent with a write of 0xFFFFFFFF -> TIE_EXPSTATE=EXPSTATE_RESET, BInterrupt06=0, count=0.
